median_filter_1d: RTL and testbench

- Streaming 1-D sliding-window median filter over R_WIDTH-bit unsigned samples.
- Takes one sample per clock and outputs, every clock, the median of the most recent N samples.
- Used as an impulse/salt-and-pepper noise rejection stage in a sample datapath; no handshake.

---
 rtl/median_filter_1d_if.sv | 19 +
 rtl/median_filter_1d.sv | 80 ++++++++
 tb/tb_median_filter_1d.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/median_filter_1d_if.sv
// Sample stream bundle for median_filter_1d: input sample X, registered median Y.
// MEDIAN_FILTER_VALID_EN adds the Y_VALID qualifier.
interface median_filter_1d_if #(
   parameter int R_WIDTH = 8
);
   logic [R_WIDTH-1:0] X;
   logic [R_WIDTH-1:0] Y;
`ifdef MEDIAN_FILTER_VALID_EN
   logic               Y_VALID;
`endif

`ifdef MEDIAN_FILTER_VALID_EN
   modport master (output X, input Y, input Y_VALID);
   modport slave  (input X, output Y, output Y_VALID);
`else
   modport master (output X, input Y);
   modport slave  (input X, output Y);
`endif
endinterface

// File: rtl/median_filter_1d.sv
// Streaming sliding-window median of the last N unsigned samples, one sample per clock.
// MEDIAN_FILTER_VALID_EN adds a Y_VALID flag that rises once the window holds only post-reset samples.
module median_filter_1d #(
   parameter int R_WIDTH = 8,
   parameter int N       = 5
) (
   input  logic             clk,
   input  logic             srst,
   median_filter_1d_if.slave bus
);
   localparam int            CW  = $clog2(N) + 1;
   localparam logic [CW-1:0] MID = CW'((N - 1) / 2);

   generate
      if ((N < 3) || ((N % 2) == 0) || (R_WIDTH < 1)) begin : g_param_check
         $error("median_filter_1d: N must be odd and >= 3, R_WIDTH >= 1");
      end
   endgenerate

   logic [R_WIDTH-1:0] win_r  [N];
   logic [CW-1:0]      rank_s [N];
   logic [R_WIDTH-1:0] median_s;
   logic [R_WIDTH-1:0] y_r;

   // Tie-safe ranking: equal values are ordered by index, so exactly one entry holds rank MID.
   always_comb begin
      median_s = {R_WIDTH{1'b0}};
      for (int i = 0; i < N; i++) begin
         rank_s[i] = {CW{1'b0}};
         for (int j = 0; j < N; j++) begin
            rank_s[i] = rank_s[i]
                      + CW'(win_r[j] < win_r[i])
                      + CW'((j < i) && (win_r[j] == win_r[i]));
         end
      end
      for (int i = 0; i < N; i++) begin
         median_s = median_s | ((rank_s[i] == MID) ? win_r[i] : {R_WIDTH{1'b0}});
      end
   end

   // Sample window shift register and registered median output.
   always_ff @(posedge clk or posedge srst) begin
      if (srst) begin
         for (int i = 0; i < N; i++) begin
            win_r[i] <= {R_WIDTH{1'b0}};
         end
         y_r <= {R_WIDTH{1'b0}};
      end else begin
         win_r[0] <= bus.X;
         for (int i = 1; i < N; i++) begin
            win_r[i] <= win_r[i-1];
         end
         y_r <= median_s;
      end
   end

   assign bus.Y = y_r;

`ifdef MEDIAN_FILTER_VALID_EN
   logic [CW-1:0] fill_cnt_r;
   logic          y_valid_r;

   // Saturating fill count; Y is trustworthy once the pre-edge window is all post-reset samples.
   always_ff @(posedge clk or posedge srst) begin
      if (srst) begin
         fill_cnt_r <= {CW{1'b0}};
         y_valid_r  <= 1'b0;
      end else begin
         if (fill_cnt_r != CW'(N)) begin
            fill_cnt_r <= fill_cnt_r + CW'(1);
         end else begin
            fill_cnt_r <= fill_cnt_r;
         end
         y_valid_r <= y_valid_r | (fill_cnt_r == CW'(N));
      end
   end

   assign bus.Y_VALID = y_valid_r;
`endif
endmodule

// File: tb/tb_median_filter_1d.sv
// Directed bench for median_filter_1d: sorting-based reference model checked every cycle,
// plus hand-computed expectations for the documented scenarios.
module tb_median_filter_1d;
   localparam int RW = 8;
   localparam int NW = 5;

   logic clk;
   logic srst;
   int   total;
   int   bad;
   bit   check_en;

   median_filter_1d_if #(.R_WIDTH(RW)) bus ();

   median_filter_1d #(.R_WIDTH(RW), .N(NW)) dut (
      .clk  (clk),
      .srst (srst),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: sort a copy of the window and take the middle element.
   function automatic logic [RW-1:0] ref_median(input logic [RW-1:0] w [NW]);
      int a [NW];
      int t;
      for (int i = 0; i < NW; i++) a[i] = int'(w[i]);
      for (int i = 0; i < NW; i++)
         for (int j = 0; j < NW - 1 - i; j++)
            if (a[j] > a[j+1]) begin
               t = a[j]; a[j] = a[j+1]; a[j+1] = t;
            end
      return RW'(a[NW/2]);
   endfunction

   logic [RW-1:0] mwin [NW];
   logic [RW-1:0] exp_y;
   int            nsamp;
   bit            exp_valid;

   always @(posedge clk or posedge srst) begin
      if (srst) begin
         for (int i = 0; i < NW; i++) mwin[i] <= '0;
         exp_y     <= '0;
         nsamp     <= 0;
         exp_valid <= 1'b0;
      end else begin
         exp_y     <= ref_median(mwin);
         exp_valid <= exp_valid || (nsamp >= NW);
         nsamp     <= nsamp + 1;
         mwin[0]   <= bus.X;
         for (int i = 1; i < NW; i++) mwin[i] <= mwin[i-1];
      end
   end

   always @(negedge clk) begin
      if (check_en) begin
         total++;
         if (bus.Y !== exp_y) begin
            bad++;
            $display("FAIL model_y t=%0t got=%0d want=%0d", $time, bus.Y, exp_y);
         end
`ifdef MEDIAN_FILTER_VALID_EN
         total++;
         if (bus.Y_VALID !== exp_valid) begin
            bad++;
            $display("FAIL model_valid t=%0t got=%0b want=%0b", $time, bus.Y_VALID, exp_valid);
         end
`endif
      end
   end

   task automatic chk(input string name, input logic [RW-1:0] got, input logic [RW-1:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d", name, got, want);
      end
   endtask

   // Drive one sample, let one rising edge capture it, return 1 time unit after the edge.
   task automatic edge_in(input logic [RW-1:0] v);
      bus.X = v;
      @(posedge clk);
      #1;
   endtask

   task automatic feed5(input logic [RW-1:0] a, b, c, d, e);
      edge_in(a); edge_in(b); edge_in(c); edge_in(d); edge_in(e);
   endtask

   // Assumes srst was released just after an edge; checks the 255 fill ramp.
   task automatic fill_check(input string tag);
      for (int k = 1; k <= 8; k++) begin
         edge_in(8'd255);
         chk($sformatf("%s_y_e%0d", tag, k), bus.Y, (k <= 3) ? 8'd0 : 8'd255);
`ifdef MEDIAN_FILTER_VALID_EN
         chk($sformatf("%s_v_e%0d", tag, k), RW'(bus.Y_VALID), (k >= 6) ? 8'd1 : 8'd0);
`endif
      end
   endtask

   task automatic mid_reset(input string tag);
      srst = 1'b1;
      #1;
      chk({tag, "_y0"}, bus.Y, 8'd0);
`ifdef MEDIAN_FILTER_VALID_EN
      chk({tag, "_v0"}, RW'(bus.Y_VALID), 8'd0);
`endif
      @(posedge clk);
      #2;
      srst = 1'b0;
   endtask

   initial begin
      total    = 0;
      bad      = 0;
      check_en = 1'b0;
      srst     = 1'b1;
      bus.X    = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_y", bus.Y, 8'd0);
      check_en = 1'b1;
      #1;
      srst = 1'b0;

      fill_check("fill");

      feed5(8'd10, 8'd200, 8'd166, 8'd131, 8'd59);
      edge_in(8'd0);
      chk("order", bus.Y, 8'd131);

      repeat (5) edge_in(8'd100);
      edge_in(8'd100);
      chk("imp_pre", bus.Y, 8'd100);
      edge_in(8'd250);
      chk("imp_hit", bus.Y, 8'd100);
      for (int k = 0; k < 5; k++) begin
         edge_in(8'd100);
         chk($sformatf("imp_post%0d", k), bus.Y, 8'd100);
      end

      feed5(8'd59, 8'd4, 8'd59, 8'd4, 8'd4);
      edge_in(8'd0);
      chk("dup_a", bus.Y, 8'd4);
      feed5(8'd59, 8'd4, 8'd59, 8'd59, 8'd4);
      edge_in(8'd0);
      chk("dup_b", bus.Y, 8'd59);

      feed5(8'd0, 8'd255, 8'd0, 8'd255, 8'd255);
      edge_in(8'd255);
      chk("extreme", bus.Y, 8'd255);
      mid_reset("ext_rst");
      fill_check("refill");

      repeat (6) edge_in(8'd200);
      chk("full200", bus.Y, 8'd200);
      mid_reset("rst200");
      fill_check("refill2");

      repeat (2) @(posedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
